// File: rtl/serial_framer.sv
// Serial frame aligner: bit-slip hunt for a sync byte, then payload byte
// delivery with a flywheel that tolerates LOSS_LIMIT-1 consecutive bad sync bytes.
module serial_framer #(
   parameter logic [7:0]  SYNC_WORD   = 8'hA5,
   parameter int unsigned PAYLOAD_LEN = 4,
   parameter int unsigned LOSS_LIMIT  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in,
   input  logic       bit_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       locked,
   output logic       sync_err
);

   localparam logic [3:0] PLEN = 4'(PAYLOAD_LEN);
   localparam logic [2:0] LLIM = 3'(LOSS_LIMIT);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

   state_t     state, state_nxt;
   logic [7:0] sr, sr_nxt, nb, dout_nxt;
   logic [2:0] bit_cnt, bit_nxt, miss_cnt, miss_nxt, miss_inc;
   logic [3:0] byte_cnt, byte_nxt, byte_inc;
   logic       dv_nxt, se_nxt;

   assign nb       = {sr[6:0], in};
   assign byte_inc = byte_cnt + 4'd1;
   assign miss_inc = miss_cnt + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         sr         <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         miss_cnt   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sync_err   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state      <= state_nxt;
         sr         <= sr_nxt;
         bit_cnt    <= bit_nxt;
         byte_cnt   <= byte_nxt;
         miss_cnt   <= miss_nxt;
         data_out   <= dout_nxt;
         data_valid <= dv_nxt;
         sync_err   <= se_nxt;
         locked     <= (state_nxt != HUNT);
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      bit_nxt   = bit_cnt;
      byte_nxt  = byte_cnt;
      miss_nxt  = miss_cnt;
      dout_nxt  = data_out;
      dv_nxt    = 1'b0;
      se_nxt    = 1'b0;
      if (bit_en) begin
         sr_nxt = nb;
         unique case (state)
            HUNT: begin
               // sr is never cleared here, so a match is honoured on any bit
               if (nb == SYNC_WORD) begin
                  state_nxt = PAYLOAD;
                  bit_nxt   = '0;
                  byte_nxt  = '0;
                  miss_nxt  = '0;
               end
            end
            PAYLOAD: begin
               bit_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  dout_nxt = nb;
                  dv_nxt   = 1'b1;
                  byte_nxt = byte_inc;
                  if (byte_inc == PLEN) state_nxt = CHECK;
               end
            end
            CHECK: begin
               bit_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_nxt = '0;
                  if (nb == SYNC_WORD) begin
                     miss_nxt  = '0;
                     state_nxt = PAYLOAD;
                  end else begin
                     se_nxt    = 1'b1;
                     miss_nxt  = miss_inc;
                     state_nxt = (miss_inc == LLIM) ? HUNT : PAYLOAD;
                  end
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_framer.sv
// Directed bench for serial_framer: lock, bit-slip hunt, flywheel, loss of lock,
// bit_en gaps and asynchronous reset mid-payload.
module tb_serial_framer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in = 1'b0;
   logic       bit_en = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, locked, sync_err;

   int unsigned total = 0, bad = 0;
   int unsigned cyc = 0, dv_seen = 0, se_seen = 0, last_dv = 0, dv_gap = 0, snap = 0;
   bit          gap = 1'b0;

   serial_framer #(.SYNC_WORD(8'hA5), .PAYLOAD_LEN(4), .LOSS_LIMIT(2)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .bit_en(bit_en),
      .data_out(data_out), .data_valid(data_valid), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int unsigned obs, input int unsigned exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      if (gap) begin
         @(negedge clk); bit_en = 1'b0;
         @(posedge clk); #1;
         chk1("idle_dv", data_valid, 1'b0);
         chk1("idle_se", sync_err, 1'b0);
      end
      @(negedge clk); in = b; bit_en = 1'b1;
      @(posedge clk); #1;
      if (data_valid) begin
         dv_seen++;
         dv_gap  = cyc - last_dv;
         last_dv = cyc;
      end
      if (sync_err) se_seen++;
   endtask

   // sends n bits of v starting at bit index hi, MSB first
   task automatic send_bits(input logic [7:0] v, input int unsigned hi, input int unsigned n);
      logic [7:0] t;
      t = v << (7 - hi);
      for (int unsigned k = 0; k < n; k++) begin
         send_bit(t[7]);
         t = t << 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      send_bits(v, 7, 8);
   endtask

   task automatic payload(input logic [7:0] v, input int unsigned spacing);
      send_byte(v);
      chk1($sformatf("dv_%h", v), data_valid, 1'b1);
      chk8($sformatf("dout_%h", v), data_out, v);
      chk1($sformatf("se_%h", v), sync_err, 1'b0);
      if (spacing != 0) chk32($sformatf("spacing_%h", v), dv_gap, spacing);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0; bit_en = 1'b0; in = 1'b0;
      #1;
      chk8("rst_dout", data_out, 8'h00);
      chk1("rst_dv", data_valid, 1'b0);
      chk1("rst_lock", locked, 1'b0);
      chk1("rst_se", sync_err, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      dv_seen = 0; se_seen = 0;
   endtask

   initial begin
      // basic frame, bit_en every cycle
      do_reset();
      send_bits(8'hA5, 7, 7);
      chk1("s1_prelock", locked, 1'b0);
      send_bits(8'hA5, 0, 1);
      chk1("s1_lock", locked, 1'b1);
      payload(8'h11, 0);
      send_bits(8'h22, 7, 1);
      chk1("s1_dv_one_cycle", data_valid, 1'b0);
      chk8("s1_dout_hold", data_out, 8'h11);
      send_bits(8'h22, 6, 7);
      chk1("s1_dv_22", data_valid, 1'b1);
      chk8("s1_dout_22", data_out, 8'h22);
      chk32("s1_spacing_22", dv_gap, 8);
      payload(8'h33, 8);
      payload(8'h44, 8);
      send_byte(8'hA5);
      chk1("s1_sync_no_dv", data_valid, 1'b0);
      chk1("s1_sync_no_se", sync_err, 1'b0);
      chk1("s1_still_locked", locked, 1'b1);
      chk32("s1_dv_count", dv_seen, 4);
      chk32("s1_se_count", se_seen, 0);

      // sync found off a byte boundary
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_bits(8'hA5, 7, 7);
      chk1("s2_prelock", locked, 1'b0);
      send_bits(8'hA5, 0, 1);
      chk1("s2_lock", locked, 1'b1);
      payload(8'h55, 0);

      // flywheel on one bad sync, then loss of lock after two consecutive
      do_reset();
      send_byte(8'hA5);
      chk1("s3_lock", locked, 1'b1);
      payload(8'h11, 0); payload(8'h22, 8); payload(8'h33, 8); payload(8'h44, 8);
      send_byte(8'h00);
      chk1("s3_bad_se", sync_err, 1'b1);
      chk1("s3_bad_locked", locked, 1'b1);
      chk1("s3_bad_no_dv", data_valid, 1'b0);
      payload(8'h55, 16); payload(8'h66, 8); payload(8'h77, 8); payload(8'h88, 8);
      send_byte(8'hA5);
      chk1("s3_good_se", sync_err, 1'b0);
      chk1("s3_good_locked", locked, 1'b1);
      payload(8'h01, 16); payload(8'h02, 8); payload(8'h03, 8); payload(8'h04, 8);
      send_byte(8'h00);
      chk1("s3_miss_cleared_se", sync_err, 1'b1);
      chk1("s3_miss_cleared_locked", locked, 1'b1);
      payload(8'h05, 16); payload(8'h06, 8); payload(8'h07, 8); payload(8'h08, 8);
      send_bits(8'hFF, 7, 7);
      chk1("s4_prefall_locked", locked, 1'b1);
      send_bits(8'hFF, 0, 1);
      chk1("s4_second_se", sync_err, 1'b1);
      chk1("s4_unlocked", locked, 1'b0);
      chk1("s4_no_dv", data_valid, 1'b0);
      snap = dv_seen;
      send_byte(8'h12);
      send_byte(8'h34);
      chk32("s4_no_dv_in_hunt", dv_seen, snap);
      chk1("s4_still_hunting", locked, 1'b0);
      chk32("s4_se_count", se_seen, 3);

      // bit_en toggling every cycle
      do_reset();
      gap = 1'b1;
      send_byte(8'hA5);
      chk1("s5_lock", locked, 1'b1);
      payload(8'h11, 0); payload(8'h22, 16); payload(8'h33, 16); payload(8'h44, 16);
      send_byte(8'hA5);
      chk1("s5_sync_no_dv", data_valid, 1'b0);
      chk1("s5_locked", locked, 1'b1);
      chk32("s5_dv_count", dv_seen, 4);
      chk32("s5_se_count", se_seen, 0);
      gap = 1'b0;

      // asynchronous reset between edges mid-payload
      do_reset();
      send_byte(8'hA5);
      payload(8'h11, 0);
      send_bits(8'hA4, 7, 7);
      chk1("s6_pre_locked", locked, 1'b1);
      chk8("s6_pre_dout", data_out, 8'h11);
      #2 rst_n = 1'b0;
      #1;
      chk8("s6_async_dout", data_out, 8'h00);
      chk1("s6_async_dv", data_valid, 1'b0);
      chk1("s6_async_lock", locked, 1'b0);
      chk1("s6_async_se", sync_err, 1'b0);
      @(negedge clk); rst_n = 1'b1; bit_en = 1'b0;
      send_bit(1'b1);
      chk1("s6_sr_cleared", locked, 1'b0);
      send_byte(8'hA5);
      chk1("s6_relock", locked, 1'b1);
      payload(8'h11, 0);

      @(negedge clk); bit_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
